ascon_sequencer: RTL

Control FSM for the ASCON-128 encryption datapath. It launches the 320-bit state assembly, drives the per-round permutation unit and its round-constant index, and sequences the key, data and domain-separation XOR strobes through initialisation, associated data, plaintext and finalisation. It exchanges 64-bit rate blocks with the upstream buffer through a valid/ready handshake and ends each message with a tag strobe and a state-clear pulse.

---
 rtl/ascon_sequencer_pkg.sv | 25 ++
 rtl/ascon_sequencer_if.sv | 9 +
 rtl/ascon_sequencer_round_counter.sv | 32 +++
 rtl/ascon_sequencer.sv | 116 +++++++++++
 4 files changed

// File: rtl/ascon_sequencer_pkg.sv
// Shared types and defaults for the ASCON-128 encryption sequencer.
package ascon_sequencer_pkg;

  localparam int ROUNDS_A_DEF = 12;
  localparam int ROUNDS_B_DEF = 6;
  localparam int ROUNDS_MAX   = 12;
  // Domain-separation word XORed into x4 between AD and PT.
  localparam logic [63:0] DSEP = 64'h1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_LOAD,
    S_INIT_PERM,
    S_INIT_KEY,
    S_AD_WAIT,
    S_AD_PERM,
    S_DSEP,
    S_PT_WAIT,
    S_PT_PERM,
    S_FINAL_KEY,
    S_FINAL_PERM,
    S_TAG
  } seq_state_t;

endpackage

// File: rtl/ascon_sequencer_if.sv
// Rate-block valid/ready handshake between the upstream buffer and the sequencer.
interface ascon_sequencer_if;
  logic block_valid;
  logic block_last;
  logic block_ready;

  modport master (output block_valid, output block_last, input block_ready);
  modport slave  (input block_valid, input block_last, output block_ready);
endinterface

// File: rtl/ascon_sequencer_round_counter.sv
// Round counter for one permutation call: counts 0..N-1 and maps it onto the
// round-constant index so shorter permutations use the tail constants.
module ascon_sequencer_round_counter
  import ascon_sequencer_pkg::*;
#(
  parameter int ROUND_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [ROUND_W-1:0] n_i,
  output logic [ROUND_W-1:0] idx_o,
  output logic               done_o
);

  logic [ROUND_W-1:0] cnt_q, cnt_d;

  always_comb begin
    done_o = en_i && (cnt_q == n_i - 1'b1);
    cnt_d  = cnt_q;
    if (clr_i || done_o) cnt_d = '0;
    else if (en_i)       cnt_d = cnt_q + 1'b1;
    idx_o = en_i ? (ROUND_W'(ROUNDS_MAX) - n_i + cnt_q) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ascon_sequencer.sv
// Control FSM for the ASCON-128 encryption datapath: init, AD, PT, final, tag.
module ascon_sequencer
  import ascon_sequencer_pkg::*;
#(
  parameter int ROUNDS_A = ROUNDS_A_DEF,
  parameter int ROUNDS_B = ROUNDS_B_DEF,
  parameter int ROUND_W  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               ad_empty_i,
  input  logic               abort_i,
  ascon_sequencer_if.slave   blk,
  output logic               assemble_o,
  output logic               clear_o,
  output logic               perm_en_o,
  output logic [ROUND_W-1:0] round_o,
  output logic               xor_data_o,
  output logic               xor_key_begin_o,
  output logic               xor_key_end_o,
  output logic               xor_dsep_o,
  output logic               cipher_valid_o,
  output logic               tag_valid_o,
  output logic               busy_o
);

  seq_state_t state_q, state_d;
  logic ad_empty_q, ad_empty_d;
  logic last_q, last_d;
  logic clr_pend_q, clr_pend_d;

  logic perm_a, perm_any, wait_st, aborting, rnd_done;
  logic [ROUND_W-1:0] n_sel;

  always_comb begin
    perm_a   = (state_q == S_INIT_PERM) || (state_q == S_FINAL_PERM);
    perm_any = perm_a || (state_q == S_AD_PERM) || (state_q == S_PT_PERM);
    wait_st  = (state_q == S_AD_WAIT) || (state_q == S_PT_WAIT);
    aborting = abort_i && (state_q != S_IDLE);
    n_sel    = perm_a ? ROUND_W'(ROUNDS_A) : ROUND_W'(ROUNDS_B);
  end

  ascon_sequencer_round_counter #(.ROUND_W(ROUND_W)) u_rnd (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (perm_any),
    .clr_i  (aborting),
    .n_i    (n_sel),
    .idx_o  (round_o),
    .done_o (rnd_done)
  );

  always_comb begin
    state_d    = state_q;
    ad_empty_d = ad_empty_q;
    last_d     = last_q;
    clr_pend_d = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d    = S_INIT_LOAD;
        ad_empty_d = ad_empty_i;
        last_d     = 1'b0;
      end
      S_INIT_LOAD:  state_d = S_INIT_PERM;
      S_INIT_PERM:  if (rnd_done) state_d = S_INIT_KEY;
      S_INIT_KEY:   state_d = ad_empty_q ? S_DSEP : S_AD_WAIT;
      S_AD_WAIT: if (blk.block_valid) begin
        last_d  = blk.block_last;
        state_d = S_AD_PERM;
      end
      S_AD_PERM:    if (rnd_done) state_d = last_q ? S_DSEP : S_AD_WAIT;
      S_DSEP:       state_d = S_PT_WAIT;
      S_PT_WAIT:    if (blk.block_valid) state_d = blk.block_last ? S_FINAL_KEY : S_PT_PERM;
      S_PT_PERM:    if (rnd_done) state_d = S_PT_WAIT;
      S_FINAL_KEY:  state_d = S_FINAL_PERM;
      S_FINAL_PERM: if (rnd_done) state_d = S_TAG;
      S_TAG:        state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
    // Abort wins over every transition; the clear pulse lands in the IDLE cycle.
    if (aborting) begin
      state_d    = S_IDLE;
      clr_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      ad_empty_q <= 1'b0;
      last_q     <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ad_empty_q <= ad_empty_d;
      last_q     <= last_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  always_comb begin
    blk.block_ready = wait_st;
    xor_data_o      = wait_st && blk.block_valid;
    cipher_valid_o  = (state_q == S_PT_WAIT) && blk.block_valid;
    assemble_o      = (state_q == S_INIT_LOAD);
    perm_en_o       = perm_any;
    xor_key_end_o   = (state_q == S_INIT_KEY);
    xor_key_begin_o = (state_q == S_FINAL_KEY);
    xor_dsep_o      = (state_q == S_DSEP);
    tag_valid_o     = (state_q == S_TAG);
    clear_o         = (state_q == S_TAG) || clr_pend_q;
    busy_o          = (state_q != S_IDLE);
  end

endmodule
